// File: rtl/logic8_nibble_seq_if.sv
// logic8_nibble_seq_if
// Operand/result bundle for the nibble-serial 8-bit logic unit.
//   start  : request strobe, sampled on the rising clock edge
//   op     : 00 AND, 01 OR, 10 XOR, 11 NOT A
//   A, B   : 8-bit operands, captured when start is accepted
//   busy   : computation in progress
//   done   : one-cycle completion strobe
//   Result : assembled 8-bit result, held until the next completion
//   zero   : Result == 0, updated together with Result
// The master modport drives the request side; the slave modport is the unit.
interface logic8_nibble_seq_if;
  logic       start;
  logic [1:0] op;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] Result;
  logic       zero;

  modport master (
    output start, op, A, B,
    input  busy, done, Result, zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, Result, zero
  );
endinterface

// File: rtl/logic8_nibble_seq.sv
// logic8_nibble_seq
// Evaluates AND / OR / XOR / NOT over 8-bit operands using one shared 4-bit
// datapath: low nibble in the LOW state, high nibble in the HIGH state, then
// the two halves are reassembled into Result with a one-cycle done strobe.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears state, operands, outputs)
//   bus  : logic8_nibble_seq_if.slave (start/op/A/B in, busy/done/Result/zero out)
// All outputs come straight from flops.
module logic8_nibble_seq (
  input  logic                        clk,
  input  logic                        rst,
  logic8_nibble_seq_if.slave          bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic       accept;

  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [1:0] op_reg;
  logic [3:0] partial_reg;

  logic       busy_reg;
  logic       done_reg;
  logic [7:0] result_reg;
  logic       zero_reg;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_out;
  logic [7:0] assembled;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic. A new request is only taken in IDLE or DONE; a start
  // seen in LOW/HIGH is dropped, not queued.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = LOW;
        end
      end
      LOW:  state_next = HIGH;
      HIGH: state_next = DONE;
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = LOW;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Shared nibble datapath: the HIGH state selects the upper halves,
  // every other state the lower halves.
  // ---------------------------------------------------------------------
  assign nib_a = (state_reg == HIGH) ? a_reg[7:4] : a_reg[3:0];
  assign nib_b = (state_reg == HIGH) ? b_reg[7:4] : b_reg[3:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      always_comb begin
        nib_out[gi] = 1'b0;
        case (op_reg)
          2'b00:   nib_out[gi] = nib_a[gi] & nib_b[gi];
          2'b01:   nib_out[gi] = nib_a[gi] | nib_b[gi];
          2'b10:   nib_out[gi] = nib_a[gi] ^ nib_b[gi];
          default: nib_out[gi] = ~nib_a[gi];
        endcase
      end
    end
  endgenerate

  assign assembled = {nib_out, partial_reg};

  // ---------------------------------------------------------------------
  // Operand capture, partial result and registered outputs. busy/done are
  // registered from the next state so they line up with the state flops.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= 8'h00;
      b_reg       <= 8'h00;
      op_reg      <= 2'b00;
      partial_reg <= 4'h0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= 8'h00;
      zero_reg    <= 1'b1;
    end else begin
      if (accept) begin
        a_reg  <= bus.A;
        b_reg  <= bus.B;
        op_reg <= bus.op;
      end
      if (state_reg == LOW) begin
        partial_reg <= nib_out;
      end
      // Result/zero change only on the edge leaving HIGH.
      if (state_reg == HIGH) begin
        result_reg <= assembled;
        zero_reg   <= (assembled == 8'h00);
      end
      busy_reg <= (state_next == LOW) || (state_next == HIGH);
      done_reg <= (state_next == DONE);
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.Result = result_reg;
  assign bus.zero   = zero_reg;

endmodule

// File: tb/tb_logic8_nibble_seq.sv
// Self-checking bench for logic8_nibble_seq: directed vectors with literal
// expectations, plus a per-cycle compare against an operation-level model.
module tb_logic8_nibble_seq;

  logic clk;
  logic rst;
  logic8_nibble_seq_if bus ();

  logic8_nibble_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] logic_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Operation-level model: age counts edges since a request was accepted
  // (-1 = nothing in flight). Result appears 3 edges after acceptance.
  int         age     = -1;
  logic [7:0] m_res   = 8'h00;
  logic [7:0] m_pend  = 8'h00;
  bit         armed   = 0;

  always @(posedge clk) begin
    if (rst) begin
      age   = -1;
      m_res = 8'h00;
      armed = 1;
    end else if ((age == -1 || age == 3) && bus.start === 1'b1) begin
      m_pend = logic_op(bus.A, bus.B, bus.op);
      age    = 1;
    end else if (age == 1) begin
      age = 2;
    end else if (age == 2) begin
      age   = 3;
      m_res = m_pend;
    end else if (age == 3) begin
      age = -1;
    end
    #1;
    if (armed) begin
      chk("model_busy",   {31'd0, bus.busy}, {31'd0, (age == 1 || age == 2)});
      chk("model_done",   {31'd0, bus.done}, {31'd0, (age == 3)});
      chk("model_result", {24'd0, bus.Result}, {24'd0, m_res});
      chk("model_zero",   {31'd0, bus.zero}, {31'd0, (m_res == 8'h00)});
    end
  end

  // Single start pulse; waits (bounded) for done and checks latency/result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [7:0] exp, input logic exp_zero);
    int n;
    int busy_n;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.op = op; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    busy_n = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1) busy_n++;
    end
    chk("latency", n, 3);
    chk("busy_cycles", busy_n, 2);
    chk("result", {24'd0, bus.Result}, {24'd0, exp});
    chk("zero", {31'd0, bus.zero}, {31'd0, exp_zero});
    $display("op=%0d A=%02h B=%02h -> Result=%02h zero=%0b latency=%0d", op, a, b,
             bus.Result, bus.zero, n);
  endtask

  logic [7:0] exp_b2b [4];
  int dones;

  initial begin
    exp_b2b[0] = 8'h24; exp_b2b[1] = 8'hBD; exp_b2b[2] = 8'h99; exp_b2b[3] = 8'h5A;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.A = 8'h00; bus.B = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_done", {31'd0, bus.done}, 32'd0);
      chk("idle_result", {24'd0, bus.Result}, 32'h00);
      chk("idle_zero", {31'd0, bus.zero}, 32'd1);
    end
    $display("reset idle: busy=%0b done=%0b Result=%02h zero=%0b", bus.busy, bus.done,
             bus.Result, bus.zero);

    // Single OR
    run_op(8'hF0, 8'h0F, 2'b01, 8'hFF, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    bus.A = 8'hA5; bus.B = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      bus.op = i[1:0];
      bus.start = 1'b1;
      repeat (3) @(negedge clk);
      chk("b2b_done", {31'd0, bus.done}, 32'd1);
      chk("b2b_result", {24'd0, bus.Result}, {24'd0, exp_b2b[i]});
      $display("b2b op=%0d A=A5 B=3C -> Result=%02h done=%0b", i, bus.Result, bus.done);
    end
    bus.start = 1'b0;
    @(negedge clk);

    // XOR to zero
    run_op(8'h5A, 8'h5A, 2'b10, 8'h00, 1'b1);

    // Operands changed during LOW must not matter
    @(negedge clk);
    bus.A = 8'hF3; bus.B = 8'h3F; bus.op = 2'b00; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.A = 8'h00; bus.B = 8'hFF; bus.op = 2'b01;
    repeat (2) @(negedge clk);
    chk("latched_done", {31'd0, bus.done}, 32'd1);
    chk("latched_result", {24'd0, bus.Result}, 32'h33);
    $display("latched AND A=F3 B=3F (changed in LOW) -> Result=%02h", bus.Result);

    // start pulses during LOW and HIGH are ignored
    @(negedge clk);
    bus.A = 8'h81; bus.B = 8'h18; bus.op = 2'b10; bus.start = 1'b1;
    @(negedge clk);
    dones = 0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.start = 1'b1;       // sampled while in LOW
    @(negedge clk);
    bus.start = 1'b1;       // sampled while in HIGH
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.done === 1'b1) dones++;
    chk("ignore_result", {24'd0, bus.Result}, 32'h99);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("ignore_done_count", dones, 1);
    $display("start in LOW/HIGH ignored: dones=%0d Result=%02h", dones, bus.Result);

    // Reset during HIGH of an OR
    @(negedge clk);
    bus.A = 8'h12; bus.B = 8'h40; bus.op = 2'b01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);         // now in HIGH
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {24'd0, bus.Result}, 32'h00);
    chk("rst_zero", {31'd0, bus.zero}, 32'd1);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("rst_no_done", dones, 0);
    $display("reset in HIGH: Result=%02h zero=%0b dones=%0d", bus.Result, bus.zero, dones);

    // rst and start on the same edge: stays idle
    bus.start = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b0;
    chk("rst_start_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("rst_start_busy2", {31'd0, bus.busy}, 32'd0);
    $display("rst+start same edge: busy=%0b", bus.busy);

    // A final NOT to confirm the unit still works
    run_op(8'h0F, 8'hAA, 2'b11, 8'hF0, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
